// File: rtl/redtin_pkg.sv
// Shared types and constants for the redtin UART receive path.
package redtin_pkg;

   // Receiver FSM states.
   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } rx_state_e;

   localparam int unsigned UART_DATA_BITS = 8;

   // 20 MHz / 115200 baud, rounded.
   localparam int unsigned BAUD_DIV_DEFAULT = 174;

endpackage

// File: rtl/redtin_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module redtin_sync_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   output logic [WIDTH-1:0]  rd_data,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign count   = count_q;
   // Head is shown combinationally; forced to zero while nothing is stored.
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   // A pop frees a slot, so a push into a full FIFO is accepted when popped together.
   assign do_pop  = rd_en & ~empty;
   assign do_push = wr_en & (~full | do_pop);

   // Occupancy next-state.
   always_comb begin
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
         count_q <= count_d;
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/redtin_uart_rx_fifo.sv
// 8N1 UART receiver feeding a FWFT byte FIFO, with framing and overflow status.
module redtin_uart_rx_fifo
   import redtin_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned ADDR_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              uart_rx,
   input  logic              rd_en,
   output logic [7:0]        rd_data,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              framing_err,
   output logic              overflow,
   input  logic              clear_overflow
);

   localparam int unsigned TIMER_W   = $clog2(BAUD_DIV);
   localparam int unsigned BIT_IDX_W = $clog2(UART_DATA_BITS);
   localparam logic [TIMER_W-1:0]   HALF_LOAD = TIMER_W'(BAUD_DIV / 2 - 1);
   localparam logic [TIMER_W-1:0]   FULL_LOAD = TIMER_W'(BAUD_DIV - 1);
   localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(UART_DATA_BITS - 1);

   rx_state_e                 state_q, state_d;
   logic                      sync1_q, rxs_q;
   logic [TIMER_W-1:0]        timer_q, timer_d;
   logic [BIT_IDX_W-1:0]      bit_idx_q, bit_idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      push_q, push_d;
   logic                      ferr_q, ferr_d;
   logic                      overflow_q, overflow_d;
   logic                      expired;
   logic                      fifo_full;
   logic                      drop;

   assign expired = (timer_q == '0);

   // Receiver next-state: sample mid-bit, shift LSB-first, flag the stop bit result.
   always_comb begin
      state_d   = state_q;
      timer_d   = expired ? timer_q : timer_q - TIMER_W'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      push_d    = 1'b0;
      ferr_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!rxs_q) begin
               state_d = StStart;
               timer_d = HALF_LOAD;
            end
         end
         StStart: begin
            if (expired) begin
               if (!rxs_q) begin
                  state_d   = StData;
                  timer_d   = FULL_LOAD;
                  bit_idx_d = '0;
               end else begin
                  // Line was back high at mid-start: treat as a glitch.
                  state_d = StIdle;
               end
            end
         end
         StData: begin
            if (expired) begin
               shift_d = {rxs_q, shift_q[UART_DATA_BITS-1:1]};
               timer_d = FULL_LOAD;
               if (bit_idx_q == LAST_BIT) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
               end
            end
         end
         StStop: begin
            if (expired) begin
               if (rxs_q) begin
                  push_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = StBreak;
               end
            end
         end
         StBreak: begin
            // Hold off until the line returns high so a held-low line is not re-read.
            if (rxs_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Synchroniser, receiver state and status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q    <= 1'b1;
         rxs_q      <= 1'b1;
         state_q    <= StIdle;
         timer_q    <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         push_q     <= 1'b0;
         ferr_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         sync1_q    <= uart_rx;
         rxs_q      <= sync1_q;
         state_q    <= state_d;
         timer_q    <= timer_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         push_q     <= push_d;
         ferr_q     <= ferr_d;
         overflow_q <= overflow_d;
      end
   end

   // A completed byte is lost only when full and not popped in the same cycle.
   assign drop       = push_q & fifo_full & ~rd_en;
   assign overflow_d = drop | (overflow_q & ~clear_overflow);

   assign framing_err = ferr_q;
   assign overflow    = overflow_q;

   // shift_q is stable during push_q since the FSM is back in idle.
   redtin_sync_fifo #(
      .DEPTH  (DEPTH),
      .WIDTH  (UART_DATA_BITS),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push_q),
      .wr_data (shift_q),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .empty   (empty),
      .full    (fifo_full),
      .count   (count)
   );

endmodule

// File: tb/tb_redtin_uart_rx_fifo.sv
// Scoreboard bench for redtin_uart_rx_fifo at 8 clocks per bit, 16-deep FIFO.
module tb_redtin_uart_rx_fifo;

   localparam int unsigned BAUD   = 8;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            uart_rx = 1'b1;
   logic            rd_en = 1'b0;
   logic            clear_overflow = 1'b0;
   logic [7:0]      rd_data;
   logic            empty;
   logic [ADDR_W:0] count;
   logic            framing_err;
   logic            overflow;

   int         n_checks = 0;
   int         n_fail = 0;
   int         ferr_cnt = 0;
   int         ferr_base;
   logic [7:0] exp_q[$];
   logic       exp_ovf = 1'b0;
   logic [7:0] partial_byte;

   redtin_uart_rx_fifo #(
      .BAUD_DIV (BAUD),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .uart_rx        (uart_rx),
      .rd_en          (rd_en),
      .rd_data        (rd_data),
      .empty          (empty),
      .count          (count),
      .framing_err    (framing_err),
      .overflow       (overflow),
      .clear_overflow (clear_overflow)
   );

   always #5 clk = ~clk;

   // Count every cycle framing_err is high, sampled mid-cycle.
   always @(negedge clk) if (framing_err) ferr_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One bit period; optionally raise rd_en in its final clock.
   task automatic drive_bit(input logic v, input bit rd_last);
      uart_rx = v;
      for (int i = 0; i < BAUD; i++) begin
         if (rd_last && i == BAUD - 1) rd_en = 1'b1;
         step();
      end
      rd_en = 1'b0;
   endtask

   // Full frame; on return the write edge (one clock after the stop sample) has passed.
   task automatic send_frame(input logic [7:0] d, input logic stop, input bit rd_at_push);
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i], 1'b0);
      if (stop) begin
         if (rd_at_push) begin
            check_val("head_before_pop", {24'b0, rd_data}, {24'b0, exp_q.pop_front()});
            exp_q.push_back(d);
         end else if (exp_q.size() == DEPTH) begin
            exp_ovf = 1'b1;
         end else begin
            exp_q.push_back(d);
         end
      end
      drive_bit(stop, rd_at_push);
   endtask

   task automatic read_check(input string tag);
      check_val({tag, "_not_empty"}, {31'b0, empty}, 32'd0);
      check_val(tag, {24'b0, rd_data}, {24'b0, exp_q.pop_front()});
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   initial begin
      repeat (3) step();
      check_val("rst_empty", {31'b0, empty}, 32'd1);
      check_val("rst_count", {27'b0, count}, 32'd0);
      check_val("rst_rd_data", {24'b0, rd_data}, 32'd0);
      check_val("rst_ferr", {31'b0, framing_err}, 32'd0);
      check_val("rst_ovf", {31'b0, overflow}, 32'd0);
      reset = 1'b0;
      repeat (4) step();

      // Basic frame and FWFT read.
      send_frame(8'h55, 1'b1, 1'b0);
      check_val("f55_empty", {31'b0, empty}, 32'd0);
      check_val("f55_count", {27'b0, count}, 32'd1);
      step();
      read_check("f55_data");
      check_val("f55_empty_after", {31'b0, empty}, 32'd1);
      check_val("f55_count_after", {27'b0, count}, 32'd0);

      // Short low glitch on an idle line.
      ferr_base = ferr_cnt;
      uart_rx = 1'b0;
      step();
      step();
      uart_rx = 1'b1;
      repeat (20) step();
      check_val("glitch_count", {27'b0, count}, 32'd0);
      check_val("glitch_ferr", ferr_cnt - ferr_base, 32'd0);
      send_frame(8'h3C, 1'b1, 1'b0);
      check_val("f3c_count", {27'b0, count}, 32'd1);
      read_check("f3c_data");

      // Bad stop bit followed by a held-low line.
      ferr_base = ferr_cnt;
      send_frame(8'hA3, 1'b0, 1'b0);
      repeat (3 * BAUD) step();
      uart_rx = 1'b1;
      repeat (2 * BAUD) step();
      check_val("ferr_pulse_cycles", ferr_cnt - ferr_base, 32'd1);
      check_val("ferr_not_stored", {27'b0, count}, 32'd0);
      send_frame(8'h12, 1'b1, 1'b0);
      check_val("f12_count", {27'b0, count}, 32'd1);
      read_check("f12_data");

      // Fill past capacity.
      ferr_base = ferr_cnt;
      for (int b = 0; b < 17; b++) send_frame(8'(b), 1'b1, 1'b0);
      check_val("full_count", {27'b0, count}, 32'd16);
      check_val("full_overflow", {31'b0, overflow}, {31'b0, exp_ovf});
      check_val("full_no_ferr", ferr_cnt - ferr_base, 32'd0);
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      exp_ovf = 1'b0;
      check_val("ovf_cleared", {31'b0, overflow}, {31'b0, exp_ovf});

      // Pop in the exact cycle of a push into the full FIFO.
      send_frame(8'h20, 1'b1, 1'b1);
      check_val("simul_count", {27'b0, count}, 32'd16);
      check_val("simul_overflow", {31'b0, overflow}, 32'd0);
      while (exp_q.size() != 0) read_check("drain_data");
      check_val("drain_empty", {31'b0, empty}, 32'd1);
      check_val("drain_count", {27'b0, count}, 32'd0);

      // Reset during DATA bit 4, with a byte already buffered.
      send_frame(8'h99, 1'b1, 1'b0);
      check_val("pre_rst_count", {27'b0, count}, 32'd1);
      ferr_base = ferr_cnt;
      partial_byte = 8'hF0;
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(partial_byte[i], 1'b0);
      uart_rx = partial_byte[4];
      repeat (BAUD / 2) step();
      reset = 1'b1;
      exp_q.delete();
      #1;
      check_val("mid_rst_empty", {31'b0, empty}, 32'd1);
      check_val("mid_rst_count", {27'b0, count}, 32'd0);
      uart_rx = 1'b1;
      step();
      reset = 1'b0;
      repeat (2 * BAUD) step();
      check_val("post_rst_empty", {31'b0, empty}, 32'd1);
      check_val("post_rst_ferr", ferr_cnt - ferr_base, 32'd0);
      send_frame(8'h81, 1'b1, 1'b0);
      check_val("f81_count", {27'b0, count}, 32'd1);
      read_check("f81_data");
      check_val("final_empty", {31'b0, empty}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/redtin_uart_rx_fifo.md
Name: redtin_uart_rx_fifo

Overview:
- UART receive front end for the logic analyzer's host link.
- Deserialises 8N1 frames from the board's uart_rx pin and buffers received bytes in a small synchronous FIFO.
- Sits directly upstream of the analyzer command decoder, which drains bytes via a first-word-fall-through (FWFT) read port.
- Reports framing errors and FIFO overflow.

Parameters:
- BAUD_DIV, 174, clocks per bit period (20 MHz / 115200, rounded); must be >= 4.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  system clock (20 MHz on the board).
- reset  in  1  asynchronous, active-high reset.
- uart_rx  in  1  asynchronous serial input; idles high.
- rd_en  in  1  pop head byte; ignored while empty.
- rd_data  out  8  FIFO head byte; valid while empty=0.
- empty  out  1  FIFO holds no bytes.
- count  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- framing_err  out  1  one-cycle pulse when a stop bit is sampled low.
- overflow  out  1  sticky; set when a completed byte is dropped because the FIFO is full.
- clear_overflow  in  1  clears overflow; a same-cycle set wins.

Behaviour:
- Reset (async assert, released on clk):
  - synchroniser flops = 1, state = IDLE, bit counter = 0, shift register = 0.
  - FIFO pointers = 0, count = 0, empty = 1, rd_data = 0.
  - framing_err = 0, overflow = 0.
  - A reset mid-frame discards the partial byte.
- Input path: 2-flop synchroniser on uart_rx; all decisions use the synchronised value rxs.
- Baud timer: down-counter reloaded on every state entry; it "expires" when it reaches 0.
- FSM:
  - IDLE: rxs==0 -> START, timer = BAUD_DIV/2 - 1.
  - START: on expiry, rxs==0 -> DATA, timer = BAUD_DIV-1, bit index = 0. If rxs==1 at expiry, the low was a glitch -> IDLE.
  - DATA: on each expiry, shift rxs in LSB-first and reload timer. After the 8th sample -> STOP.
  - STOP: on expiry:
    - rxs==1: push byte and go to IDLE.
    - rxs==0: pulse framing_err for 1 cycle, discard byte, go to BREAK.
  - BREAK: wait for rxs==1, then IDLE. Prevents re-triggering on a held-low line.
- Latency:
  - Byte is written one clock after the stop-bit sample.
  - empty falls and count increments on that same write edge.
  - rd_data shows the byte in the cycle after the write.
- FIFO (FWFT):
  - rd_en with empty=0 advances the head; rd_data updates the next cycle.
  - Pointers wrap modulo DEPTH; count is never wrapped.
  - Push when full, no rd_en: byte dropped, overflow=1, count stays DEPTH.
  - Push when full with rd_en the same cycle: pop and push both occur, count stays DEPTH, no overflow.
  - Push when empty with rd_en: rd_en ignored, count becomes 1.
- framing_err and a push never occur in the same cycle.

Decomposition:
- Shared package redtin_pkg:
  - rx state enum (IDLE, START, DATA, STOP, BREAK).
  - UART_DATA_BITS = 8.
  - Default BAUD_DIV constant for 20 MHz / 115200.
- One sub-module, redtin_sync_fifo (parameterised DEPTH/WIDTH, FWFT, count output). It is reused later for the uart_tx readout path.
- Receiver FSM, synchroniser and baud timer live in the top module.

Test Plan (BAUD_DIV=8, DEPTH=16 for simulation speed):
- Send frame 0x55 at 8 clk/bit -> one clock after the stop sample: empty=0, count=1; next cycle rd_data=0x55; pulse rd_en -> empty=1, count=0.
- Drive a 2-clock low glitch on idle uart_rx -> FSM returns to IDLE, count=0, framing_err never asserts; a following 0x3C frame is received correctly.
- Send 0xA3 with stop bit low, hold the line low 3 bit periods, then high; then send 0x12 -> framing_err high exactly 1 cycle, 0xA3 not stored; 0x12 is received with count=1.
- Send 0x00..0x10 (17 bytes) without reading -> count=16, overflow=1 after the 17th; reads return 0x00..0x0F in order; clear_overflow -> overflow=0.
- With the FIFO full, assert rd_en in the exact cycle of the next push -> count stays 16, overflow stays 0, head advances by one.
- Assert reset during DATA bit 4 of 0xF0 -> empty=1, count=0, no framing_err; after release a full 0x81 frame is received correctly.
